// File: rtl/sram_pkg.sv
// Shared constants for the asynchronous SRAM controller: state encodings,
// byte-lane enable patterns and the wait-state bound.
package sram_pkg;

    localparam int WAIT_MAX = 15;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_RD       = 3'd1;
    localparam logic [2:0] S_WR_SETUP = 3'd2;
    localparam logic [2:0] S_WR_PULSE = 3'd3;
    localparam logic [2:0] S_WR_HOLD  = 3'd4;
    localparam logic [2:0] S_DONE     = 3'd5;

    // Lane patterns are {ub_n, lb_n}, active low.
    localparam logic [1:0] LANE_WORD = 2'b00;
    localparam logic [1:0] LANE_LO   = 2'b10;
    localparam logic [1:0] LANE_HI   = 2'b01;
    localparam logic [1:0] LANE_OFF  = 2'b11;

    function automatic logic [1:0] lane_sel(input logic byte_op, input logic a0);
        if (!byte_op) return LANE_WORD;
        return a0 ? LANE_HI : LANE_LO;
    endfunction

endpackage

// File: rtl/sram_ctrl.sv
// Single-access controller for a 16-bit asynchronous SRAM behind the bus
// ram_* port; all strobes and read data are registered.
module sram_ctrl
    import sram_pkg::*;
#(
    parameter int AW          = 18,
    parameter int WAIT_CYCLES = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [21:0]   ram_addr,
    input  logic [15:0]   ram_wdata,
    output logic [15:0]   ram_rdata,
    input  logic          ram_rd,
    input  logic          ram_wr,
    input  logic          ram_byte_op,
    output logic          ram_done,
    output logic [AW-1:0] sram_a,
    inout  wire  [15:0]   sram_dq,
    output logic          sram_ce_n,
    output logic          sram_oe_n,
    output logic          sram_we_n,
    output logic          sram_ub_n,
    output logic          sram_lb_n
);

    localparam int         WAIT_EFF = (WAIT_CYCLES > WAIT_MAX) ? WAIT_MAX : WAIT_CYCLES;
    localparam logic [3:0] WAIT_LD  = 4'(WAIT_EFF);

    logic [2:0]    r_state;
    logic [2:0]    w_next;
    logic [3:0]    r_wcnt;
    logic [AW-1:0] r_a;
    logic [15:0]   r_wdata;
    logic [15:0]   r_rdata;
    logic [1:0]    r_lanes;
    logic [1:0]    r_lane_pins;
    logic          r_ce_n;
    logic          r_oe_n;
    logic          r_we_n;
    logic          r_dq_oe;
    logic          r_done;
    logic          w_accept;
    logic          w_last;
    logic          w_next_act;
    logic          w_next_wr;
    logic [1:0]    w_lanes;
    logic          w_unused_addr;

    assign w_accept      = (r_state == S_IDLE) && (ram_wr || ram_rd);
    assign w_last        = (r_wcnt == 4'd0);
    assign w_lanes       = w_accept ? lane_sel(ram_byte_op, ram_addr[0]) : r_lanes;
    assign w_next_wr     = (w_next == S_WR_SETUP) || (w_next == S_WR_PULSE) || (w_next == S_WR_HOLD);
    assign w_next_act    = w_next_wr || (w_next == S_RD);
    assign w_unused_addr = ^ram_addr[21:AW+1];

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (ram_wr)      w_next = S_WR_SETUP;
                else if (ram_rd) w_next = S_RD;
            end
            S_RD:       if (w_last) w_next = S_DONE;
            S_WR_SETUP: w_next = S_WR_PULSE;
            S_WR_PULSE: if (w_last) w_next = S_WR_HOLD;
            S_WR_HOLD:  w_next = S_DONE;
            S_DONE:     w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    // Strobes are registered from the next state so they line up with the
    // state register and never glitch at the pins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_wcnt      <= 4'd0;
            r_a         <= '0;
            r_wdata     <= 16'd0;
            r_rdata     <= 16'd0;
            r_lanes     <= LANE_OFF;
            r_lane_pins <= LANE_OFF;
            r_ce_n      <= 1'b1;
            r_oe_n      <= 1'b1;
            r_we_n      <= 1'b1;
            r_dq_oe     <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state != w_next)  r_wcnt <= WAIT_LD;
            else if (r_wcnt != 4'd0) r_wcnt <= r_wcnt - 4'd1;

            if (w_accept) begin
                r_a     <= ram_addr[AW:1];
                r_wdata <= ram_byte_op ? {2{ram_wdata[7:0]}} : ram_wdata;
                r_lanes <= w_lanes;
            end

            if ((r_state == S_RD) && w_last) r_rdata <= sram_dq;

            r_ce_n      <= !w_next_act;
            r_oe_n      <= (w_next != S_RD);
            r_we_n      <= (w_next != S_WR_PULSE);
            r_dq_oe     <= w_next_wr;
            r_lane_pins <= w_next_act ? w_lanes : LANE_OFF;
            r_done      <= (w_next == S_DONE);
        end
    end

    assign sram_dq   = r_dq_oe ? r_wdata : 16'hzzzz;
    assign sram_a    = r_a;
    assign ram_rdata = r_rdata;
    assign ram_done  = r_done;
    assign sram_ce_n = r_ce_n;
    assign sram_oe_n = r_oe_n;
    assign sram_we_n = r_we_n;
    assign sram_ub_n = r_lane_pins[1];
    assign sram_lb_n = r_lane_pins[0];

endmodule
